// File: rtl/cfg_vpd_pkg.sv
// Shared types and constants for the VPD capability engine.
package cfg_vpd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam int VPD_F_BIT   = 15;
  localparam int ERR_W       = 3;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_UNIMPL  = 1;
  localparam int ERR_BUSY    = 2;

  localparam logic [31:0] VPD_TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/cfg_vpd_if.sv
// Request/completion handshake between the VPD capability engine and the VPD slave.
interface cfg_vpd_if;

  logic [14:0] cfg_vpd_addr;
  logic        cfg_vpd_wren;
  logic [31:0] cfg_vpd_wdata;
  logic        cfg_vpd_rden;
  logic [31:0] vpd_cfg_rdata;
  logic        vpd_cfg_done;
  logic        vpd_err_unimplemented_addr;

  modport master (
    output cfg_vpd_addr,
    output cfg_vpd_wren,
    output cfg_vpd_wdata,
    output cfg_vpd_rden,
    input  vpd_cfg_rdata,
    input  vpd_cfg_done,
    input  vpd_err_unimplemented_addr
  );

  modport slave (
    input  cfg_vpd_addr,
    input  cfg_vpd_wren,
    input  cfg_vpd_wdata,
    input  cfg_vpd_rden,
    output vpd_cfg_rdata,
    output vpd_cfg_done,
    output vpd_err_unimplemented_addr
  );

endinterface

// File: rtl/cfg_vpd_timer.sv
// Outstanding-request watchdog: clear/enable counter with a terminal-count flag.
module cfg_vpd_timer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMR_W          = 16
) (
  input  logic clock_afu,
  input  logic reset_afu_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count_reg;

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + TMR_W'(1);
    end
  end

  assign tc = en && (count_reg == TC_VAL);

endmodule

// File: rtl/cfg_vpd_ctrl.sv
// VPD capability engine: turns VPD Address/Data config writes into one held
// read or write request, tracks the F flag and records sticky errors.
module cfg_vpd_ctrl
  import cfg_vpd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMR_W          = 16
) (
  input  logic             clock_afu,
  input  logic             reset_afu_n,
  input  logic             cfg_vpd_addr_we,
  input  logic [15:0]      cfg_vpd_addr_wdata,
  input  logic             cfg_vpd_data_we,
  input  logic [31:0]      cfg_vpd_data_wdata,
  output logic [15:0]      vpd_addr_reg,
  output logic [31:0]      vpd_data_reg,
  input  logic             err_clr,
  output logic             vpd_busy,
  output logic [ERR_W-1:0] vpd_err,
  cfg_vpd_if.master        vpd
);

  state_t           state_reg, state_next;
  logic             start, done_ok, timer_tc, tmo, finish;
  logic [ERR_W-1:0] err_set, err_next, err_reg;

  assign vpd_busy = (state_reg != IDLE);
  assign start    = !vpd_busy && cfg_vpd_addr_we;
  assign done_ok  = vpd_busy && vpd.vpd_cfg_done;
  // A done in the terminal-count cycle completes normally and suppresses the timeout.
  assign tmo      = timer_tc && !vpd.vpd_cfg_done;
  assign finish   = done_ok || tmo;

  cfg_vpd_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clock_afu   (clock_afu),
    .reset_afu_n (reset_afu_n),
    .clr         (start),
    .en          (vpd_busy),
    .tc          (timer_tc)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cfg_vpd_addr_we) state_next = cfg_vpd_addr_wdata[VPD_F_BIT] ? WR : RD;
      RD, WR:  if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Config writes land only while idle; data is captured alongside the address
  // so a same-cycle write request carries the new data.
  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      vpd_addr_reg <= '0;
      vpd_data_reg <= '0;
    end else if (!vpd_busy) begin
      if (cfg_vpd_data_we) vpd_data_reg <= cfg_vpd_data_wdata;
      if (cfg_vpd_addr_we) vpd_addr_reg <= cfg_vpd_addr_wdata;
    end else if (state_reg == RD) begin
      if (done_ok) begin
        vpd_data_reg            <= vpd.vpd_cfg_rdata;
        vpd_addr_reg[VPD_F_BIT] <= 1'b1;
      end else if (tmo) begin
        vpd_data_reg            <= VPD_TIMEOUT_RDATA;
        vpd_addr_reg[VPD_F_BIT] <= 1'b1;
      end
    end else if (finish) begin
      vpd_addr_reg[VPD_F_BIT] <= 1'b0;
    end
  end

  assign err_set[ERR_TIMEOUT] = tmo;
  assign err_set[ERR_UNIMPL]  = done_ok && vpd.vpd_err_unimplemented_addr;
  assign err_set[ERR_BUSY]    = vpd_busy && (cfg_vpd_addr_we || cfg_vpd_data_we);

  // Setting outranks clearing so an event coincident with err_clr is not lost.
  generate
    for (genvar gi = 0; gi < ERR_W; gi++) begin : g_err
      assign err_next[gi] = err_set[gi] || (err_reg[gi] && !err_clr);
    end
  endgenerate

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      err_reg <= '0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign vpd_err           = err_reg;
  assign vpd.cfg_vpd_rden  = (state_reg == RD);
  assign vpd.cfg_vpd_wren  = (state_reg == WR);
  assign vpd.cfg_vpd_addr  = vpd_addr_reg[14:0];
  assign vpd.cfg_vpd_wdata = vpd_data_reg;

endmodule

// File: tb/tb_cfg_vpd_ctrl.sv
// Scoreboard bench for cfg_vpd_ctrl: stimulus queues expected requests and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_cfg_vpd_ctrl;

  logic        clock_afu = 1'b0;
  logic        reset_afu_n = 1'b0;
  logic        cfg_vpd_addr_we = 1'b0;
  logic [15:0] cfg_vpd_addr_wdata = '0;
  logic        cfg_vpd_data_we = 1'b0;
  logic [31:0] cfg_vpd_data_wdata = '0;
  logic [15:0] vpd_addr_reg;
  logic [31:0] vpd_data_reg;
  logic        err_clr = 1'b0;
  logic        vpd_busy;
  logic [2:0]  vpd_err;

  cfg_vpd_if vif ();

  cfg_vpd_ctrl #(.TIMEOUT_CYCLES(8), .TMR_W(16)) dut (
    .clock_afu          (clock_afu),
    .reset_afu_n        (reset_afu_n),
    .cfg_vpd_addr_we    (cfg_vpd_addr_we),
    .cfg_vpd_addr_wdata (cfg_vpd_addr_wdata),
    .cfg_vpd_data_we    (cfg_vpd_data_we),
    .cfg_vpd_data_wdata (cfg_vpd_data_wdata),
    .vpd_addr_reg       (vpd_addr_reg),
    .vpd_data_reg       (vpd_data_reg),
    .err_clr            (err_clr),
    .vpd_busy           (vpd_busy),
    .vpd_err            (vpd_err),
    .vpd                (vif.master)
  );

  always #5 clock_afu = ~clock_afu;

  typedef struct {
    logic        rd;
    logic [14:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [15:0] areg;
    logic [31:0] dreg;
    logic [2:0]  err;
    int          dur;
  } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_afu);
    #1;
  endtask

  // Monitor
  logic prev_req = 1'b0;
  logic prev_busy = 1'b0;
  int   busy_cnt = 0;
  req_t mr;
  cmp_t mc;

  initial begin
    forever begin
      @(negedge clock_afu);
      if (!reset_afu_n) begin
        prev_req  = 1'b0;
        prev_busy = 1'b0;
        busy_cnt  = 0;
        continue;
      end
      if ((vif.cfg_vpd_rden || vif.cfg_vpd_wren) && !prev_req) begin
        busy_cnt = 0;
        if (req_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_request: got rden=%b wren=%b expected none",
                   vif.cfg_vpd_rden, vif.cfg_vpd_wren);
        end else begin
          mr = req_q.pop_front();
          chk("req_rden", 32'(vif.cfg_vpd_rden), 32'(mr.rd));
          chk("req_wren", 32'(vif.cfg_vpd_wren), 32'(!mr.rd));
          chk("req_addr", 32'(vif.cfg_vpd_addr), 32'(mr.addr));
          if (!mr.rd) chk("req_wdata", vif.cfg_vpd_wdata, mr.wdata);
          $display("request %s addr=%h wdata=%h", mr.rd ? "RD" : "WR",
                   vif.cfg_vpd_addr, vif.cfg_vpd_wdata);
        end
      end
      if (vpd_busy) busy_cnt++;
      if (prev_busy && !vpd_busy) begin
        if (cmp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_completion: got busy falling expected none");
        end else begin
          mc = cmp_q.pop_front();
          chk("cmp_duration", 32'(busy_cnt), 32'(mc.dur));
          chk("cmp_addr_reg", 32'(vpd_addr_reg), 32'(mc.areg));
          chk("cmp_data_reg", vpd_data_reg, mc.dreg);
          chk("cmp_err", 32'(vpd_err), 32'(mc.err));
          chk("cmp_req_low", 32'({vif.cfg_vpd_rden, vif.cfg_vpd_wren}), 32'd0);
          $display("complete addr_reg=%h data_reg=%h err=%b cycles=%0d",
                   vpd_addr_reg, vpd_data_reg, vpd_err, busy_cnt);
        end
      end
      prev_req  = vif.cfg_vpd_rden || vif.cfg_vpd_wren;
      prev_busy = vpd_busy;
    end
  end

  // Stimulus
  initial begin
    vif.vpd_cfg_rdata              = '0;
    vif.vpd_cfg_done               = 1'b0;
    vif.vpd_err_unimplemented_addr = 1'b0;

    #12;
    chk("rst_addr_reg", 32'(vpd_addr_reg), 32'd0);
    chk("rst_data_reg", vpd_data_reg, 32'd0);
    chk("rst_busy", 32'(vpd_busy), 32'd0);
    chk("rst_err", 32'(vpd_err), 32'd0);
    chk("rst_req", 32'({vif.cfg_vpd_rden, vif.cfg_vpd_wren}), 32'd0);
    @(posedge clock_afu);
    #1 reset_afu_n = 1'b1;
    tick();

    // 1: read, done three cycles after the request
    req_q.push_back('{rd: 1'b1, addr: 15'h0010, wdata: 32'h0});
    cmp_q.push_back('{areg: 16'h8010, dreg: 32'hA5A5_1234, err: 3'b000, dur: 3});
    cfg_vpd_addr_we = 1'b1; cfg_vpd_addr_wdata = 16'h0010;
    tick();
    cfg_vpd_addr_we = 1'b0;
    chk("rd_f_low", 32'(vpd_addr_reg), 32'h0010);
    tick(); tick();
    vif.vpd_cfg_done = 1'b1; vif.vpd_cfg_rdata = 32'hA5A5_1234;
    tick();
    vif.vpd_cfg_done = 1'b0; vif.vpd_cfg_rdata = '0;
    tick();

    // 2: write using previously loaded data
    cfg_vpd_data_we = 1'b1; cfg_vpd_data_wdata = 32'hDEAD_BEEF;
    tick();
    cfg_vpd_data_we = 1'b0;
    chk("data_we_idle", vpd_data_reg, 32'hDEAD_BEEF);
    chk("data_we_no_req", 32'(vpd_busy), 32'd0);
    req_q.push_back('{rd: 1'b0, addr: 15'h0020, wdata: 32'hDEAD_BEEF});
    cmp_q.push_back('{areg: 16'h0020, dreg: 32'hDEAD_BEEF, err: 3'b000, dur: 1});
    cfg_vpd_addr_we = 1'b1; cfg_vpd_addr_wdata = 16'h8020;
    tick();
    cfg_vpd_addr_we = 1'b0;
    chk("wr_f_high", 32'(vpd_addr_reg), 32'h8020);
    vif.vpd_cfg_done = 1'b1;
    tick();
    vif.vpd_cfg_done = 1'b0;
    tick();

    // 3: read timeout, then err_clr
    req_q.push_back('{rd: 1'b1, addr: 15'h0030, wdata: 32'h0});
    cmp_q.push_back('{areg: 16'h8030, dreg: 32'hFFFF_FFFF, err: 3'b001, dur: 8});
    cfg_vpd_addr_we = 1'b1; cfg_vpd_addr_wdata = 16'h0030;
    tick();
    cfg_vpd_addr_we = 1'b0;
    repeat (10) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 32'(vpd_err), 32'd0);

    // 4: writes while busy are dropped; done with unimplemented address
    req_q.push_back('{rd: 1'b1, addr: 15'h0040, wdata: 32'h0});
    cmp_q.push_back('{areg: 16'h8040, dreg: 32'h1234_5678, err: 3'b110, dur: 3});
    cfg_vpd_addr_we = 1'b1; cfg_vpd_addr_wdata = 16'h0040;
    tick();
    cfg_vpd_addr_wdata = 16'h8055;
    tick();
    cfg_vpd_addr_we = 1'b0;
    cfg_vpd_data_we = 1'b1; cfg_vpd_data_wdata = 32'h1111_1111;
    tick();
    cfg_vpd_data_we = 1'b0;
    chk("busy_addr_kept", 32'(vpd_addr_reg), 32'h0040);
    chk("busy_data_kept", vpd_data_reg, 32'hFFFF_FFFF);
    chk("busy_err", 32'(vpd_err), 32'b100);
    chk("busy_req_kept", 32'({vif.cfg_vpd_rden, vif.cfg_vpd_wren}), 32'b10);
    vif.vpd_cfg_done = 1'b1; vif.vpd_cfg_rdata = 32'h1234_5678;
    vif.vpd_err_unimplemented_addr = 1'b1;
    tick();
    vif.vpd_cfg_done = 1'b0; vif.vpd_cfg_rdata = '0;
    vif.vpd_err_unimplemented_addr = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // 5: same-cycle data+addr write; done lands on the terminal count
    req_q.push_back('{rd: 1'b0, addr: 15'h0004, wdata: 32'h0000_00C3});
    cmp_q.push_back('{areg: 16'h0004, dreg: 32'h0000_00C3, err: 3'b000, dur: 8});
    cfg_vpd_addr_we = 1'b1; cfg_vpd_addr_wdata = 16'h8004;
    cfg_vpd_data_we = 1'b1; cfg_vpd_data_wdata = 32'h0000_00C3;
    tick();
    cfg_vpd_addr_we = 1'b0; cfg_vpd_data_we = 1'b0;
    repeat (7) tick();
    vif.vpd_cfg_done = 1'b1;
    tick();
    vif.vpd_cfg_done = 1'b0;
    tick();

    // 6: reset mid-write, then a spurious done
    req_q.push_back('{rd: 1'b0, addr: 15'h0008, wdata: 32'h0000_0077});
    cfg_vpd_addr_we = 1'b1; cfg_vpd_addr_wdata = 16'h8008;
    cfg_vpd_data_we = 1'b1; cfg_vpd_data_wdata = 32'h0000_0077;
    tick();
    cfg_vpd_addr_we = 1'b0; cfg_vpd_data_we = 1'b0;
    tick(); tick();
    #2 reset_afu_n = 1'b0;
    #1;
    chk("async_wren", 32'(vif.cfg_vpd_wren), 32'd0);
    chk("async_addr_reg", 32'(vpd_addr_reg), 32'd0);
    chk("async_data_reg", vpd_data_reg, 32'd0);
    chk("async_busy", 32'(vpd_busy), 32'd0);
    @(posedge clock_afu);
    #1 reset_afu_n = 1'b1;
    tick();
    vif.vpd_cfg_done = 1'b1; vif.vpd_cfg_rdata = 32'h9999_9999;
    tick();
    vif.vpd_cfg_done = 1'b0; vif.vpd_cfg_rdata = '0;
    tick();
    chk("spurious_busy", 32'(vpd_busy), 32'd0);
    chk("spurious_data", vpd_data_reg, 32'd0);
    chk("spurious_addr", 32'(vpd_addr_reg), 32'd0);
    chk("spurious_err", 32'(vpd_err), 32'd0);

    repeat (3) tick();
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("cmp_q_drained", 32'(cmp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
